// File: rtl/fifo_rd_if.sv
// Read-domain stream bundle between the async FIFO read logic,
// the output stage and the downstream consumer.
interface fifo_rd_if #(
    parameter int DSIZE = 8,
    parameter int CNTW  = 16
);
    logic             rempty;
    logic [DSIZE-1:0] rdata;
    logic             rinc;
    logic             m_valid;
    logic [DSIZE-1:0] m_data;
    logic             m_ready;
    logic             flush;
    logic [1:0]       occ;
    logic [CNTW-1:0]  rd_cnt;

    modport master (
        input  rempty, rdata, m_ready, flush,
        output rinc, m_valid, m_data, occ, rd_cnt
    );

    modport slave (
        output rempty, rdata, m_ready, flush,
        input  rinc, m_valid, m_data, occ, rd_cnt
    );
endinterface

// File: rtl/fifo_rd_stage.sv
// Two-entry registered output buffer on the FIFO read side; pops are
// driven only from registered state so m_ready never reaches rinc.
module fifo_rd_stage #(
    parameter int DSIZE = 8,
    parameter int CNTW  = 16
) (
    input  logic      rclk,
    input  logic      rrst,
    fifo_rd_if.master bus
);
    logic [1:0]       occ_q, occ_d;
    logic [DSIZE-1:0] slot0_q, slot0_d;
    logic [DSIZE-1:0] slot1_q, slot1_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             pop, take;

    always_comb begin
        pop     = ~bus.rempty & (occ_q != 2'd2) & ~bus.flush & ~rrst;
        take    = (occ_q != 2'd0) & bus.m_ready;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        cnt_d   = cnt_q + CNTW'(take);
        occ_d   = occ_q + {1'b0, pop} - {1'b0, take};
        case (occ_q)
            2'd0: if (pop) slot0_d = bus.rdata;
            2'd1: begin
                if (pop && take)  slot0_d = bus.rdata;
                else if (pop)     slot1_d = bus.rdata;
            end
            2'd2: if (take) slot0_d = slot1_q;
            default: ;
        endcase
        // A take in the flush cycle still counts; only the buffer is dropped.
        if (bus.flush) occ_d = 2'd0;
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            occ_q   <= 2'd0;
            slot0_q <= '0;
            slot1_q <= '0;
            cnt_q   <= '0;
        end else begin
            occ_q   <= occ_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.rinc    = pop;
    assign bus.m_valid = (occ_q != 2'd0);
    assign bus.m_data  = slot0_q;
    assign bus.occ     = occ_q;
    assign bus.rd_cnt  = cnt_q;
endmodule

// File: tb/tb_fifo_rd_stage.sv
// Directed + randomized bench for fifo_rd_stage against a queue model
// of the FIFO source and the two-word output buffer.
module tb_fifo_rd_stage;
    logic rclk;
    logic rrst;

    fifo_rd_if #(.DSIZE(8), .CNTW(16)) bus ();
    fifo_rd_if #(.DSIZE(8), .CNTW(4))  busw ();

    fifo_rd_stage #(.DSIZE(8), .CNTW(16)) u_dut (
        .rclk (rclk),
        .rrst (rrst),
        .bus  (bus.master)
    );

    fifo_rd_stage #(.DSIZE(8), .CNTW(4)) u_dutw (
        .rclk (rclk),
        .rrst (rrst),
        .bus  (busw.master)
    );

    assign busw.rempty  = bus.rempty;
    assign busw.rdata   = bus.rdata;
    assign busw.m_ready = bus.m_ready;
    assign busw.flush   = bus.flush;

    initial begin
        rclk = 1'b0;
        forever #5 rclk = ~rclk;
    end

    int checks   = 0;
    int failures = 0;
    int cnt      = 0;
    int ptr      = 0;
    int rinc_seen = 0;
    logic [7:0] src[$];
    logic [7:0] mq[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic new_src(input int n, input int base, input bit rnd);
        src.delete();
        ptr = 0;
        for (int i = 0; i < n; i++)
            src.push_back(rnd ? 8'($urandom) : 8'(base + i));
    endtask

    task automatic cycle(input bit want, input bit rdy,
                         input bit fl, input bit rst);
        bit e_pop;
        bit e_take;
        rrst        = rst;
        bus.flush   = fl;
        bus.m_ready = rdy;
        if (rst) begin
            bus.rempty = 1'b0;
            bus.rdata  = 8'hA5;
        end else begin
            bus.rempty = !(want && ptr < src.size());
            bus.rdata  = (ptr < src.size()) ? src[ptr] : 8'($urandom);
        end
        @(negedge rclk);
        e_pop  = !bus.rempty && mq.size() < 2 && !fl && !rst;
        e_take = mq.size() > 0 && rdy;
        if (bus.rinc === 1'b1) rinc_seen++;
        chk("rinc", 32'(bus.rinc), 32'(e_pop));
        chk("m_valid", 32'(bus.m_valid), 32'(mq.size() != 0));
        chk("occ", 32'(bus.occ), 32'(mq.size()));
        chk("rd_cnt", 32'(bus.rd_cnt), 32'(cnt & 32'hFFFF));
        chk("rd_cnt_w4", 32'(busw.rd_cnt), 32'(cnt & 32'hF));
        if (mq.size() > 0) chk("m_data", 32'(bus.m_data), 32'(mq[0]));
        @(posedge rclk);
        if (rst) begin
            mq.delete();
            cnt = 0;
        end else begin
            if (e_take) begin
                void'(mq.pop_front());
                cnt++;
            end
            if (fl) mq.delete();
            if (e_pop) begin
                mq.push_back(bus.rdata);
                ptr++;
            end
        end
        #1;
    endtask

    initial begin
        int base;
        rrst        = 1'b1;
        bus.rempty  = 1'b0;
        bus.rdata   = 8'hA5;
        bus.m_ready = 1'b0;
        bus.flush   = 1'b0;

        // reset with data pending: nothing may pop
        new_src(0, 0, 0);
        repeat (3) cycle(1, 0, 0, 1);
        chk("rst_rinc", 32'(bus.rinc), 32'd0);
        chk("rst_mdata", 32'(bus.m_data), 32'd0);
        chk("rst_occ", 32'(bus.occ), 32'd0);
        chk("rst_cnt", 32'(bus.rd_cnt), 32'd0);

        // streaming
        new_src(8, 1, 0);
        repeat (10) cycle(1, 1, 0, 0);
        chk("stream_cnt", 32'(bus.rd_cnt), 32'd8);

        // back-pressure
        new_src(5, 1, 0);
        base = rinc_seen;
        repeat (5) cycle(1, 0, 0, 0);
        chk("bp_pops", 32'(rinc_seen - base), 32'd2);
        chk("bp_occ", 32'(bus.occ), 32'd2);
        chk("bp_head", 32'(bus.m_data), 32'h01);
        repeat (8) cycle(1, 1, 0, 0);
        chk("bp_cnt", 32'(bus.rd_cnt), 32'd13);

        // rempty toggling every cycle
        new_src(60, 0, 1);
        for (int i = 0; i < 60; i++)
            cycle(i[0], 1'($urandom), 0, 0);
        repeat (4) cycle(0, 1, 0, 0);

        // flush with buffer full
        cycle(0, 0, 0, 1);
        new_src(4, 8'h10, 0);
        repeat (3) cycle(1, 0, 0, 0);
        chk("fl_occ", 32'(bus.occ), 32'd2);
        chk("fl_head", 32'(bus.m_data), 32'h10);
        cycle(1, 1, 1, 0);
        chk("fl_cnt", 32'(bus.rd_cnt), 32'd1);
        chk("fl_valid", 32'(bus.m_valid), 32'd0);
        cycle(1, 1, 0, 0);
        chk("fl_next", 32'(bus.m_data), 32'h12);

        // random mix including mid-burst flush and reset
        new_src(400, 0, 1);
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom), 1'($urandom),
                  $urandom_range(9) == 0, $urandom_range(49) == 0);

        // 17 handshakes from reset: 4-bit counter wraps to 1
        cycle(0, 0, 0, 1);
        new_src(17, 8'h40, 0);
        repeat (20) cycle(1, 1, 0, 0);
        chk("wrap_w4", 32'(busw.rd_cnt), 32'd1);
        chk("wrap_w16", 32'(bus.rd_cnt), 32'd17);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo_rd_stage.md
# fifo_rd_stage

Read-side output stage of the asynchronous FIFO, clocked by rclk. It sits directly downstream of the read-pointer/empty logic and FIFO memory, and consumes rempty and the asynchronously-read rdata. It drives rinc to pop words into a two-entry registered output buffer, then presents them on a valid/ready stream to the read-domain consumer. rinc is derived only from registered state, so consumer back-pressure (m_ready) never reaches the pointer logic combinationally.

## Interface
- DSIZE, 8, data word width (matches FIFO memory width)
- CNTW, 16, width of delivered-word counter

- rclk  in  1  read-domain clock; all state updates on rising edge
- rrst  in  1  synchronous, active-high reset
- rempty  in  1  registered empty flag from read-pointer logic; 1 = no readable word
- rdata  in  DSIZE  FIFO memory output at current read address; valid whenever rempty=0
- rinc  out  1  pop request to read-pointer logic; pointer advances at next rclk edge
- m_valid  out  1  output word available
- m_data  out  DSIZE  output word (head of buffer)
- m_ready  in  1  consumer accepts m_data when m_valid=1
- flush  in  1  synchronous discard of buffered words (FIFO contents untouched)
- occ  out  2  buffer occupancy, 0..2
- rd_cnt  out  CNTW  count of completed output handshakes, wraps modulo 2^CNTW

## Operation
- Storage: slot0 (head, drives m_data) and slot1; occ register; m_valid = (occ != 0), registered.
- pop = rinc = ~rempty & (occ != 2) & ~flush & ~rrst. Combinational from registered signals only.
- take = m_valid & m_ready.
- On a pop edge, rdata is captured; the captured word is the one addressed before the pointer advances.
- Next occupancy = occ + pop − take, never outside 0..2. pop is impossible at occ=2; take is impossible at occ=0.
- Slot update, by case (occ, take, pop):
  - (0,-,1): slot0←rdata
  - (1,0,1): slot1←rdata
  - (1,1,1): slot0←rdata
  - (1,1,0): slot0 unchanged (stale), occ→0
  - (2,1,0): slot0←slot1
  - all others: hold
- Ordering: words leave in exact FIFO order; no duplication, no loss except via flush.
- flush=1: occ→0 at next edge; rinc forced 0 that cycle. A take in the flush cycle still completes and counts.
- rd_cnt increments by 1 on every take, wraps from 2^CNTW−1 to 0.
- m_data is held stable while m_valid=1 and m_ready=0.
- m_data holds its last value when occ=0; the consumer must ignore it.
- rrst=1: occ=0, m_valid=0, m_data=0, slot1=0, rd_cnt=0, rinc=0 (combinationally, same cycle). rrst has priority over flush, pop and take, including mid-burst.

## Timing
- Reset values: rinc=0, m_valid=0, m_data=0, occ=0, rd_cnt=0.
- Latency: rempty falls in cycle N with occ<2 → rinc=1 in N → m_valid=1 and m_data=word in N+1.
- Throughput: 1 word/cycle sustained while rempty=0 and m_ready=1. Steady state is occ=1 with pop and take each cycle.
- Back-pressure: with m_ready=0, at most 2 pops occur, then rinc=0 until a take.
- After a take at occ=2, rinc reasserts in the next cycle (occ=1). No bubble is visible to the consumer because slot1 covers it.
- rempty rising stops pops in the same cycle; buffered words still drain.
- flush asserted in cycle N: m_valid=0 in N+1. Pops may resume in N+1 if flush=0.

## Test plan
- Reset: hold rrst=1 with rempty=0, rdata=0xA5 → rinc=0, m_valid=0, occ=0, rd_cnt=0. First rclk after release: rinc=1.
- Streaming: rempty=0 for 8 cycles, rdata 0x01..0x08 advancing per pop, m_ready=1 → m_data 0x01..0x08 on consecutive cycles starting 1 cycle after first rinc; rd_cnt=8.
- Back-pressure: 5 words available, m_ready=0 → exactly 2 rinc pulses, occ=2, m_data=0x01 stable. Release m_ready → 0x01..0x05 delivered in order, no duplicates.
- Empty boundary: rempty toggles 0/1 every cycle, m_ready random → rinc never 1 while rempty=1; output sequence equals pop sequence.
- Flush mid-burst: occ=2 holding 0x10,0x11, assert flush with m_ready=1 → 0x10 counted (rd_cnt+1), occ=0 and m_valid=0 next cycle, rinc=0 during flush; next word delivered is the next FIFO word 0x12.
- Counter wrap: CNTW=4, 17 handshakes → rd_cnt=1.
